// File: rtl/t_strobe_pkg.sv
// Shared encodings for the toggle-strobe generator.
package t_strobe_pkg;

  // Run-mode encoding on the mode input.
  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BURST  = 2'b01;
  localparam logic [1:0] MODE_CONT   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // FIRE: a pulse was issued at the last edge; GAP: waiting for the interval to expire.
  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    GAP
  } state_e;

endpackage

// File: rtl/t_strobe_tick.sv
// Interval down-counter: load on each pulse edge, count down to zero between pulses.
module t_strobe_tick #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         zero
);

  logic [W-1:0] val_q;

  // Load takes priority; counting stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
    end else if (load) begin
      val_q <= load_val;
    end else if (count && (val_q != '0)) begin
      val_q <= val_q - W'(1);
    end
  end

  assign zero = (val_q == '0);

endmodule

// File: rtl/t_strobe_gen.sv
// Programmable toggle-strobe generator driving the t input of a T flip-flop.
module t_strobe_gen
  import t_strobe_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] rem_q, rem_d;   // pulses still to issue after the current one
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_q, t_d;
  logic             done_q, done_d;

  logic             tick_load;
  logic [DIV_W-1:0] tick_load_val;
  logic             tick_count;
  logic             tick_zero;
  logic [DIV_W-1:0] div_in_eff;

  assign div_in_eff = (div == '0) ? DIV_W'(1) : div;

  t_strobe_tick #(
    .W (DIV_W)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (tick_load),
    .load_val (tick_load_val),
    .count    (tick_count),
    .zero     (tick_zero)
  );

  // Next-state, pulse scheduling and handshake decode.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    div_d         = div_q;
    rem_d         = rem_q;
    cnt_d         = cnt_q;
    t_d           = 1'b0;
    done_d        = 1'b0;
    tick_load     = 1'b0;
    tick_load_val = div_q - DIV_W'(1);
    tick_count    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          mode_d        = mode;
          div_d         = div_in_eff;
          cnt_d         = '0;
          tick_load     = 1'b1;
          tick_load_val = div_in_eff - DIV_W'(1);
          if ((mode == MODE_BURST) && (burst_len == '0)) begin
            // Empty burst: complete immediately without ever going busy.
            done_d = 1'b1;
          end else begin
            t_d     = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = FIRE;
            rem_d   = (mode == MODE_BURST) ? burst_len - CNT_W'(1) : '0;
          end
        end
      end
      FIRE, GAP: begin
        if (stop) begin
          // Stop beats a pulse scheduled for the same edge.
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((mode_q != MODE_CONT) && (rem_q == '0)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tick_zero) begin
          t_d       = 1'b1;
          tick_load = 1'b1;
          state_d   = FIRE;
          if (~&cnt_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (mode_q == MODE_BURST) begin
            rem_d = rem_q - CNT_W'(1);
          end
        end else begin
          tick_count = 1'b1;
          state_d    = GAP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      div_q   <= DIV_W'(1);
      rem_q   <= '0;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      done_q  <= done_d;
    end
  end

  assign t         = t_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_t_strobe_gen.sv
// Directed self-checking bench: t_strobe_gen driving a T flip-flop.
module tb_t_strobe_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] div;
  logic [7:0] burst_len;
  logic       t;
  logic       busy;
  logic       done;
  logic [7:0] pulse_cnt;
  logic       q;

  int n_tests = 0;
  int n_fail  = 0;

  t_strobe_gen #(
    .DIV_W (8),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .div       (div),
    .burst_len (burst_len),
    .t         (t),
    .busy      (busy),
    .done      (done),
    .pulse_cnt (pulse_cnt)
  );

  // Downstream T flip-flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else if (t) q <= ~q;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; div = 8'd0; burst_len = 8'd0;
    #12;
    chk("reset_t", t, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", pulse_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Burst div=3 len=4, with a start pulse injected mid-run and div changed after E0.
    mode = 2'b01; div = 8'd3; burst_len = 8'd4; start = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 0) begin start = 1'b0; div = 8'd9; burst_len = 8'd2; end
      if (e == 4) start = 1'b1;
      if (e == 5) start = 1'b0;
      chk($sformatf("burst_t_E%0d", e), t, (e == 0 || e == 3 || e == 6 || e == 9) ? 1 : 0);
      chk($sformatf("burst_busy_E%0d", e), busy, (e < 10) ? 1 : 0);
      chk($sformatf("burst_done_E%0d", e), done, (e == 10) ? 1 : 0);
    end
    chk("burst_cnt", pulse_cnt, 4);
    chk("burst_q", q, 0);
    tick();
    chk("burst_done_one_cycle", done, 0);
    chk("burst_idle_after_start_busy", busy, 0);

    // Single div=7, start together with stop (start accepted).
    mode = 2'b00; div = 8'd7; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("single_t_E0", t, 1);
    chk("single_busy_E0", busy, 1);
    chk("single_cnt_E0", pulse_cnt, 1);
    tick();
    chk("single_t_E1", t, 0);
    chk("single_done_E1", done, 1);
    chk("single_busy_E1", busy, 0);
    chk("single_cnt", pulse_cnt, 1);
    chk("single_q", q, 1);
    tick();

    // Continuous div=0, stop sampled at E5.
    mode = 2'b10; div = 8'd0; start = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      tick();
      start = 1'b0;
      chk($sformatf("cont1_t_E%0d", e), t, (e < 5) ? 1 : 0);
      chk($sformatf("cont1_busy_E%0d", e), busy, (e < 5) ? 1 : 0);
      chk($sformatf("cont1_done_E%0d", e), done, (e == 5) ? 1 : 0);
      if (e == 4) stop = 1'b1;
    end
    stop = 1'b0;
    chk("cont1_cnt", pulse_cnt, 5);
    chk("cont1_q", q, 0);
    tick();

    // Continuous div=2, stop on the E4 pulse edge.
    mode = 2'b10; div = 8'd2; start = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      tick();
      start = 1'b0;
      chk($sformatf("cont2_t_E%0d", e), t, (e == 0 || e == 2) ? 1 : 0);
      chk($sformatf("cont2_done_E%0d", e), done, (e == 4) ? 1 : 0);
      if (e == 3) stop = 1'b1;
    end
    stop = 1'b0;
    chk("cont2_cnt", pulse_cnt, 2);
    chk("cont2_busy", busy, 0);
    tick();

    // Reserved mode: nothing changes.
    mode = 2'b11; div = 8'd1; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("rsvd_t", t, 0);
    chk("rsvd_busy", busy, 0);
    chk("rsvd_done", done, 0);
    chk("rsvd_cnt", pulse_cnt, 2);

    // Zero-length burst.
    mode = 2'b01; div = 8'd1; burst_len = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zlen_done", done, 1);
    chk("zlen_busy", busy, 0);
    chk("zlen_t", t, 0);
    chk("zlen_cnt", pulse_cnt, 0);
    tick();
    chk("zlen_done_clear", done, 0);
    chk("zlen_busy_after", busy, 0);

    // Reset mid-burst after the third pulse (E4).
    mode = 2'b01; div = 8'd2; burst_len = 8'd10; start = 1'b1;
    for (int e = 0; e <= 4; e++) begin
      tick();
      start = 1'b0;
    end
    chk("rst_mid_t_before", t, 1);
    chk("rst_mid_cnt_before", pulse_cnt, 3);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_t", t, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_cnt", pulse_cnt, 0);
    #3;
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy || t) ndone++;
    end
    chk("rst_no_done_after", ndone, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
